// File: rtl/uart_tx_fifo.sv
// UART transmitter with an internal transmit FIFO, runtime parity/stop-bit
// selection and a valid/ready write port; characters leave LSB-first on DATAo.
module uart_tx_fifo #(
  parameter int unsigned FREQ_CLK   = 100000000,
  parameter int unsigned DATA_WDTH  = 8,
  parameter int unsigned FIFO_DEPTH = 16
) (
  input  logic                        CLKip,
  input  logic                        RSTi,
  input  logic [DATA_WDTH-1:0]        TXi,
  input  logic                        TX_VALIDi,
  output logic                        TX_READYo,
  input  logic [31:0]                 BAUD_RATEi,
  input  logic [1:0]                  PARITYi,
  input  logic                        STOP2i,
  output logic                        BUSYo,
  output logic                        DONEo,
  output logic                        OVFo,
  output logic [$clog2(FIFO_DEPTH):0] FIFO_CNTo,
  output logic                        DATAo
);
  localparam int unsigned AW = $clog2(FIFO_DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = 32;
  localparam int unsigned IW = $clog2(DATA_WDTH);
  localparam logic [BW-1:0] DEFAULT_BAUD = BW'(115200);

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP} state_t;

  logic [DATA_WDTH-1:0] r_mem [FIFO_DEPTH];
  logic [AW-1:0]        r_wr_ptr, r_rd_ptr;
  logic [CW-1:0]        r_cnt;
  logic                 r_ovf;
  logic                 w_full, w_not_empty, w_wr, w_pop;

  state_t               r_state, w_state_nxt;
  logic [BW-1:0]        r_tick, w_tick_nxt;
  logic [BW-1:0]        r_period, w_period_nxt;
  logic [DATA_WDTH-1:0] r_shift, w_shift_nxt;
  logic [IW-1:0]        r_bit_idx, w_bit_idx_nxt;
  logic                 r_par_en, w_par_en_nxt;
  logic                 r_par_bit, w_par_bit_nxt;
  logic                 r_stop2, w_stop2_nxt;
  logic                 r_stop_sec, w_stop_sec_nxt;
  logic                 r_data, w_data_nxt;
  logic                 r_busy, r_done, w_done_nxt;

  logic [BW-1:0]        w_baud, w_div, w_period_new;
  logic [DATA_WDTH-1:0] w_pop_char;
  logic                 w_tick_last;

  assign w_full      = (r_cnt == CW'(FIFO_DEPTH));
  assign w_not_empty = (r_cnt != '0);
  assign w_wr        = TX_VALIDi && !w_full;
  assign TX_READYo   = !w_full;
  assign FIFO_CNTo   = r_cnt;
  assign OVFo        = r_ovf;
  assign DATAo       = r_data;
  assign BUSYo       = r_busy;
  assign DONEo       = r_done;

  // Frame settings are captured from these at pop time only
  assign w_baud       = (BAUD_RATEi == '0) ? DEFAULT_BAUD : BAUD_RATEi;
  assign w_div        = BW'(FREQ_CLK) / w_baud;
  assign w_period_new = (w_div == '0) ? BW'(1) : w_div;
  assign w_pop_char   = r_mem[r_rd_ptr];
  assign w_tick_last  = (r_tick == r_period - BW'(1));

  always_ff @(posedge CLKip) begin
    if (w_wr) r_mem[r_wr_ptr] <= TXi;
  end

  always_ff @(posedge CLKip) begin
    if (RSTi) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_cnt    <= '0;
      r_ovf    <= 1'b0;
    end else begin
      if (w_wr)  r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop) r_rd_ptr <= r_rd_ptr + AW'(1);
      if (w_wr && !w_pop)      r_cnt <= r_cnt + CW'(1);
      else if (!w_wr && w_pop) r_cnt <= r_cnt - CW'(1);
      if (TX_VALIDi && w_full) r_ovf <= 1'b1;
    end
  end

  always_ff @(posedge CLKip) begin
    if (RSTi) begin
      r_state    <= S_IDLE;
      r_tick     <= '0;
      r_period   <= BW'(1);
      r_shift    <= '0;
      r_bit_idx  <= '0;
      r_par_en   <= 1'b0;
      r_par_bit  <= 1'b0;
      r_stop2    <= 1'b0;
      r_stop_sec <= 1'b0;
      r_data     <= 1'b1;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      r_tick     <= w_tick_nxt;
      r_period   <= w_period_nxt;
      r_shift    <= w_shift_nxt;
      r_bit_idx  <= w_bit_idx_nxt;
      r_par_en   <= w_par_en_nxt;
      r_par_bit  <= w_par_bit_nxt;
      r_stop2    <= w_stop2_nxt;
      r_stop_sec <= w_stop_sec_nxt;
      r_data     <= w_data_nxt;
      r_busy     <= (w_state_nxt != S_IDLE);
      r_done     <= w_done_nxt;
    end
  end

  // Line value is computed for the next state so DATAo is registered
  always_comb begin
    w_state_nxt    = r_state;
    w_tick_nxt     = r_tick + BW'(1);
    w_period_nxt   = r_period;
    w_shift_nxt    = r_shift;
    w_bit_idx_nxt  = r_bit_idx;
    w_par_en_nxt   = r_par_en;
    w_par_bit_nxt  = r_par_bit;
    w_stop2_nxt    = r_stop2;
    w_stop_sec_nxt = r_stop_sec;
    w_data_nxt     = r_data;
    w_done_nxt     = 1'b0;
    w_pop          = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_tick_nxt = '0;
        w_data_nxt = 1'b1;
        w_pop      = w_not_empty;
      end
      S_START: if (w_tick_last) begin
        w_state_nxt   = S_DATA;
        w_tick_nxt    = '0;
        w_bit_idx_nxt = '0;
        w_data_nxt    = r_shift[0];
      end
      S_DATA: if (w_tick_last) begin
        w_tick_nxt = '0;
        if (r_bit_idx == IW'(DATA_WDTH - 1)) begin
          if (r_par_en) begin
            w_state_nxt = S_PARITY;
            w_data_nxt  = r_par_bit;
          end else begin
            w_state_nxt    = S_STOP;
            w_data_nxt     = 1'b1;
            w_stop_sec_nxt = 1'b0;
          end
        end else begin
          w_bit_idx_nxt = r_bit_idx + IW'(1);
          w_shift_nxt   = r_shift >> 1;
          w_data_nxt    = r_shift[1];
        end
      end
      S_PARITY: if (w_tick_last) begin
        w_state_nxt    = S_STOP;
        w_tick_nxt     = '0;
        w_data_nxt     = 1'b1;
        w_stop_sec_nxt = 1'b0;
      end
      S_STOP: if (w_tick_last) begin
        w_tick_nxt = '0;
        if (r_stop2 && !r_stop_sec) begin
          w_stop_sec_nxt = 1'b1;
        end else begin
          w_state_nxt = S_IDLE;
          w_data_nxt  = 1'b1;
          w_done_nxt  = 1'b1;
          w_pop       = w_not_empty;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_data_nxt  = 1'b1;
      end
    endcase
    // A pop always starts a new frame with freshly latched settings
    if (w_pop) begin
      w_state_nxt   = S_START;
      w_tick_nxt    = '0;
      w_data_nxt    = 1'b0;
      w_shift_nxt   = w_pop_char;
      w_period_nxt  = w_period_new;
      w_par_en_nxt  = (PARITYi == 2'b01) || (PARITYi == 2'b10);
      w_par_bit_nxt = (PARITYi == 2'b01) ? ~(^w_pop_char) : ^w_pop_char;
      w_stop2_nxt   = STOP2i;
    end
  end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Scoreboard bench for uart_tx_fifo: writes push expected frames, a monitor
// checks every serial bit, frame timing, BUSYo and DONEo against them.
`timescale 1ns/1ps
module tb_uart_tx_fifo;
  localparam int unsigned FREQ  = 100000000;
  localparam int unsigned DW    = 8;
  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [DW-1:0] ch;
    logic [31:0]   baud;
    logic [1:0]    par;
    logic          stop2;
    int            wr_cyc;
  } exp_t;

  logic          clk = 1'b0;
  logic          RSTi, TX_VALIDi, TX_READYo, STOP2i, BUSYo, DONEo, OVFo, DATAo;
  logic [DW-1:0] TXi;
  logic [31:0]   BAUD_RATEi;
  logic [1:0]    PARITYi;
  logic [CW-1:0] FIFO_CNTo;

  int   n_checks = 0;
  int   n_errors = 0;
  int   cyc = 0;
  int   n_done = 0;
  exp_t exp_q[$];
  logic mon_abort = 1'b0;
  logic mon_in_frame = 1'b0;
  logic [31:0] cur_baud;
  logic [1:0]  cur_par;
  logic        cur_stop2;

  uart_tx_fifo #(.FREQ_CLK(FREQ), .DATA_WDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLKip(clk), .RSTi(RSTi), .TXi(TXi), .TX_VALIDi(TX_VALIDi),
    .TX_READYo(TX_READYo), .BAUD_RATEi(BAUD_RATEi), .PARITYi(PARITYi),
    .STOP2i(STOP2i), .BUSYo(BUSYo), .DONEo(DONEo), .OVFo(OVFo),
    .FIFO_CNTo(FIFO_CNTo), .DATAo(DATAo)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (DONEo === 1'b1) n_done <= n_done + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  task automatic check(input string nm, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int period_of(input logic [31:0] baud);
    longint b, p;
    b = (baud == 32'd0) ? 64'd115200 : 64'(baud);
    p = longint'(FREQ) / b;
    return (p == 0) ? 1 : int'(p);
  endfunction

  // Frame as a list of line levels, one entry per bit period
  function automatic int frame_bits(input exp_t e, output logic b [0:15]);
    int n;
    int ones;
    ones = $countones(e.ch);
    for (int i = 0; i < 16; i++) b[i] = 1'b1;
    b[0] = 1'b0;
    n = 1;
    for (int i = 0; i < int'(DW); i++) begin b[n] = e.ch[i]; n++; end
    if (e.par == 2'b01) begin b[n] = (ones % 2 == 0); n++; end
    else if (e.par == 2'b10) begin b[n] = (ones % 2 == 1); n++; end
    b[n] = 1'b1; n++;
    if (e.stop2) begin b[n] = 1'b1; n++; end
    return n;
  endfunction

  task automatic set_cfg(input logic [31:0] baud, input logic [1:0] par, input logic s2);
    cur_baud = baud; cur_par = par; cur_stop2 = s2;
    BAUD_RATEi = baud; PARITYi = par; STOP2i = s2;
  endtask

  // Called at a negedge; presents one write for a cycle, ends at the next negedge
  task automatic send(input logic [DW-1:0] ch, input logic exp_rdy);
    exp_t e;
    TXi = ch;
    TX_VALIDi = 1'b1;
    check("tx_ready", int'(TX_READYo), int'(exp_rdy));
    if (exp_rdy) begin
      e.ch = ch; e.baud = cur_baud; e.par = cur_par; e.stop2 = cur_stop2; e.wr_cyc = cyc;
      exp_q.push_back(e);
    end
    @(negedge clk);
    TX_VALIDi = 1'b0;
  endtask

  task automatic wait_idle(input int bound);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || mon_in_frame) && i < bound) begin
      @(negedge clk);
      i++;
    end
    check("wait_idle_bound", int'(i < bound), 1);
    @(negedge clk);
  endtask

  initial begin : monitor
    exp_t e;
    logic b [0:15];
    logic seen, aborted, busy_bad, done_bad, recheck, nxt_busy;
    int   n, p, exp_start, prev_end;
    recheck = 1'b0;
    prev_end = 0;
    forever begin
      if (!recheck) @(negedge clk);
      recheck = 1'b0;
      if (mon_abort) begin prev_end = 0; continue; end
      if (RSTi !== 1'b0 || DATAo !== 1'b0) continue;
      if (exp_q.size() == 0) begin
        check("unexpected_frame", 1, 0);
        for (int i = 0; i < 20000 && DATAo !== 1'b1; i++) @(negedge clk);
        continue;
      end
      e = exp_q.pop_front();
      mon_in_frame = 1'b1;
      exp_start = (prev_end > e.wr_cyc + 2) ? prev_end : e.wr_cyc + 2;
      check("start_cycle", cyc, exp_start);
      n = frame_bits(e, b);
      p = period_of(e.baud);
      aborted = 1'b0; busy_bad = 1'b0; done_bad = 1'b0;
      for (int k = 0; k < n && !aborted; k++) begin
        seen = b[k];
        for (int c = 0; c < p; c++) begin
          if (mon_abort) begin aborted = 1'b1; break; end
          if (DATAo !== b[k] && seen === b[k]) seen = DATAo;
          if (BUSYo !== 1'b1) busy_bad = 1'b1;
          if (DONEo !== 1'b0 && !(k == 0 && c == 0)) done_bad = 1'b1;
          @(negedge clk);
        end
        if (!aborted) check("frame_bit", int'(seen), int'(b[k]));
      end
      if (aborted) begin
        mon_in_frame = 1'b0;
        prev_end = 0;
        continue;
      end
      check("busy_in_frame", int'(busy_bad), 0);
      check("done_in_frame", int'(done_bad), 0);
      check("done_pulse", int'(DONEo), 1);
      prev_end = cyc;
      nxt_busy = (exp_q.size() > 0) && (exp_q[0].wr_cyc <= cyc - 2);
      check("busy_at_frame_end", int'(BUSYo), int'(nxt_busy));
      mon_in_frame = 1'b0;
      recheck = 1'b1;
    end
  end

  initial begin : stim
    int d0, lows, len, nch, gap, w;
    logic [31:0] bauds [6];
    bauds[0] = 32'd10000000; bauds[1] = 32'd25000000; bauds[2] = 32'd50000000;
    bauds[3] = 32'd100000000; bauds[4] = 32'd200000000; bauds[5] = 32'd33333333;
    TXi = '0; TX_VALIDi = 1'b0; RSTi = 1'b1;
    set_cfg(32'd10000000, 2'b00, 1'b0);
    repeat (3) @(negedge clk);
    RSTi = 1'b0;
    check("rst_data", int'(DATAo), 1);
    check("rst_busy", int'(BUSYo), 0);
    check("rst_done", int'(DONEo), 0);
    check("rst_ovf", int'(OVFo), 0);
    check("rst_cnt", int'(FIFO_CNTo), 0);
    check("rst_ready", int'(TX_READYo), 1);

    // 8N1 A5, latency, settings changed mid-frame must not alter the frame
    @(negedge clk);
    d0 = n_done;
    send(8'hA5, 1'b1);
    check("cnt_after_write", int'(FIFO_CNTo), 1);
    check("latency_idle", int'(DATAo), 1);
    @(negedge clk);
    check("latency_start", int'(DATAo), 0);
    check("busy_start", int'(BUSYo), 1);
    BAUD_RATEi = 32'd25000000; PARITYi = 2'b10; STOP2i = 1'b1;
    wait_idle(400);
    check("busy_after", int'(BUSYo), 0);
    check("done_count_basic", n_done - d0, 1);

    // even then odd parity, two stop bits
    set_cfg(32'd10000000, 2'b10, 1'b1);
    send(8'hA5, 1'b1);
    wait_idle(400);
    set_cfg(32'd10000000, 2'b01, 1'b1);
    send(8'hA5, 1'b1);
    wait_idle(400);

    // back-to-back burst of four
    set_cfg(32'd10000000, 2'b00, 1'b0);
    d0 = n_done;
    for (int i = 0; i < 4; i++) send(DW'($urandom), 1'b1);
    wait_idle(1000);
    check("done_count_burst", n_done - d0, 4);

    // fill past full: 17 accepted, 18th dropped
    d0 = n_done;
    for (int i = 0; i < 18; i++) begin
      if (i == 17) check("ovf_before", int'(OVFo), 0);
      send(DW'($urandom), i < 17);
    end
    check("cnt_full", int'(FIFO_CNTo), 16);
    check("ready_full", int'(TX_READYo), 0);
    check("ovf_set", int'(OVFo), 1);
    wait_idle(3000);
    check("ovf_sticky", int'(OVFo), 1);
    check("done_count_ovf", n_done - d0, 17);

    // reset during the data bits with three queued
    d0 = n_done;
    for (int i = 0; i < 4; i++) send(DW'($urandom), 1'b1);
    repeat (20) @(negedge clk);
    check("cnt_before_rst", int'(FIFO_CNTo), 3);
    mon_abort = 1'b1;
    RSTi = 1'b1;
    @(negedge clk);
    RSTi = 1'b0;
    exp_q.delete();
    check("midrst_data", int'(DATAo), 1);
    check("midrst_busy", int'(BUSYo), 0);
    check("midrst_cnt", int'(FIFO_CNTo), 0);
    check("midrst_ready", int'(TX_READYo), 1);
    check("midrst_ovf", int'(OVFo), 0);
    lows = 0;
    for (int i = 0; i < 300; i++) begin
      if (DATAo !== 1'b1 || BUSYo !== 1'b0) lows++;
      @(negedge clk);
    end
    check("midrst_line_quiet", lows, 0);
    check("midrst_no_done", n_done - d0, 0);
    mon_abort = 1'b0;
    @(negedge clk);

    // zero baud selects 115200
    set_cfg(32'd0, 2'b00, 1'b0);
    send(8'h55, 1'b1);
    @(negedge clk);
    len = 0;
    while (DATAo === 1'b0 && len < 2000) begin len++; @(negedge clk); end
    check("default_start_len", len, 868);
    wait_idle(10000);

    // randomized rounds
    for (int r = 0; r < 6; r++) begin
      set_cfg(bauds[$urandom_range(0, 5)], 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)));
      nch = int'($urandom_range(1, 24));
      for (int j = 0; j < nch; j++) begin
        w = 0;
        while (exp_q.size() >= int'(DEPTH) && w < 5000) begin @(negedge clk); w++; end
        gap = int'($urandom_range(0, 3));
        repeat (gap) @(negedge clk);
        send(DW'($urandom), 1'b1);
      end
      wait_idle(20000);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
